// File: rtl/mem_req_arbiter.sv
// Two-port round-robin arbiter that shares one block-wide memory request/response
// channel between an instruction-cache and a data-cache requester.
module mem_req_arbiter #(
    parameter int ADDR_WIDTH     = 30,
    parameter int WORD_WIDTH     = 32,
    parameter int BLOCK_SIZE     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            rq0_addr,
    input  logic                             rq0_cs,
    input  logic                             rq0_rw,
    input  logic [WORD_WIDTH*BLOCK_SIZE-1:0] rq0_data,
    output logic                             rs0_ack,
    output logic [WORD_WIDTH*BLOCK_SIZE-1:0] rs0_data,
    input  logic [ADDR_WIDTH-1:0]            rq1_addr,
    input  logic                             rq1_cs,
    input  logic                             rq1_rw,
    input  logic [WORD_WIDTH*BLOCK_SIZE-1:0] rq1_data,
    output logic                             rs1_ack,
    output logic [WORD_WIDTH*BLOCK_SIZE-1:0] rs1_data,
    output logic [ADDR_WIDTH-1:0]            mrq_addr,
    output logic                             mrq_cs,
    output logic                             mrq_rw,
    output logic [WORD_WIDTH*BLOCK_SIZE-1:0] mrq_data,
    input  logic                             mrs_ack,
    input  logic [WORD_WIDTH*BLOCK_SIZE-1:0] mrs_data,
    output logic                             grant_id,
    output logic                             busy,
    output logic                             timeout_err
);
    localparam int BLOCK_WIDTH = WORD_WIDTH * BLOCK_SIZE;
    localparam int CNT_WIDTH   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Requester inputs gathered into arrays so arbitration can index by port.
    logic                   rq_cs   [2];
    logic                   rq_rw   [2];
    logic [ADDR_WIDTH-1:0]  rq_addr [2];
    logic [BLOCK_WIDTH-1:0] rq_data [2];

    assign rq_cs[0]   = rq0_cs;
    assign rq_cs[1]   = rq1_cs;
    assign rq_rw[0]   = rq0_rw;
    assign rq_rw[1]   = rq1_rw;
    assign rq_addr[0] = rq0_addr;
    assign rq_addr[1] = rq1_addr;
    assign rq_data[0] = rq0_data;
    assign rq_data[1] = rq1_data;

    state_t                 state_reg,       state_next;
    logic                   last_grant_reg,  last_grant_next;
    logic                   grant_id_reg,    grant_id_next;
    logic                   busy_reg,        busy_next;
    logic                   timeout_err_reg, timeout_err_next;
    logic [CNT_WIDTH-1:0]   cnt_reg,         cnt_next;
    logic [ADDR_WIDTH-1:0]  lat_addr_reg,    lat_addr_next;
    logic                   lat_rw_reg,      lat_rw_next;
    logic [BLOCK_WIDTH-1:0] lat_data_reg,    lat_data_next;
    logic                   mrq_cs_reg,      mrq_cs_next;
    logic [ADDR_WIDTH-1:0]  mrq_addr_reg,    mrq_addr_next;
    logic                   mrq_rw_reg,      mrq_rw_next;
    logic [BLOCK_WIDTH-1:0] mrq_data_reg,    mrq_data_next;

    logic                   rs_ack_reg   [2];
    logic                   rs_ack_next  [2];
    logic [BLOCK_WIDTH-1:0] rs_data_reg  [2];
    logic [BLOCK_WIDTH-1:0] rs_data_next [2];

    logic                   pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            last_grant_reg  <= 1'b1;
            grant_id_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
            cnt_reg         <= '0;
            lat_addr_reg    <= '0;
            lat_rw_reg      <= 1'b0;
            lat_data_reg    <= '0;
            mrq_cs_reg      <= 1'b0;
            mrq_addr_reg    <= '0;
            mrq_rw_reg      <= 1'b0;
            mrq_data_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            last_grant_reg  <= last_grant_next;
            grant_id_reg    <= grant_id_next;
            busy_reg        <= busy_next;
            timeout_err_reg <= timeout_err_next;
            cnt_reg         <= cnt_next;
            lat_addr_reg    <= lat_addr_next;
            lat_rw_reg      <= lat_rw_next;
            lat_data_reg    <= lat_data_next;
            mrq_cs_reg      <= mrq_cs_next;
            mrq_addr_reg    <= mrq_addr_next;
            mrq_rw_reg      <= mrq_rw_next;
            mrq_data_reg    <= mrq_data_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_ff @(posedge clk) begin
                if (rst) begin
                    rs_ack_reg[gi]  <= 1'b0;
                    rs_data_reg[gi] <= '0;
                end else begin
                    rs_ack_reg[gi]  <= rs_ack_next[gi];
                    rs_data_reg[gi] <= rs_data_next[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        last_grant_next  = last_grant_reg;
        grant_id_next    = grant_id_reg;
        busy_next        = busy_reg;
        timeout_err_next = timeout_err_reg;
        cnt_next         = cnt_reg;
        lat_addr_next    = lat_addr_reg;
        lat_rw_next      = lat_rw_reg;
        lat_data_next    = lat_data_reg;
        mrq_cs_next      = mrq_cs_reg;
        mrq_addr_next    = mrq_addr_reg;
        mrq_rw_next      = mrq_rw_reg;
        mrq_data_next    = mrq_data_reg;
        pick             = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rs_ack_next[p]  = 1'b0;
            rs_data_next[p] = rs_data_reg[p];
        end

        case (state_reg)
            ST_IDLE: begin
                if (rq_cs[0] || rq_cs[1]) begin
                    // On a tie the port that did not win last time goes first.
                    if (rq_cs[0] && rq_cs[1]) begin
                        pick = ~last_grant_reg;
                    end else begin
                        pick = rq_cs[1];
                    end
                    lat_addr_next   = rq_addr[pick];
                    lat_rw_next     = rq_rw[pick];
                    lat_data_next   = rq_data[pick];
                    grant_id_next   = pick;
                    last_grant_next = pick;
                    busy_next       = 1'b1;
                    state_next      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mrq_cs_next   = 1'b1;
                mrq_addr_next = lat_addr_reg;
                mrq_rw_next   = lat_rw_reg;
                mrq_data_next = lat_data_reg;
                cnt_next      = '0;
                state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (mrs_ack) begin
                    rs_data_next[grant_id_reg] = mrs_data;
                    rs_ack_next[grant_id_reg]  = 1'b1;
                    mrq_cs_next                = 1'b0;
                    state_next                 = ST_DONE;
                end else if (cnt_reg == CNT_LIMIT) begin
                    // Abort: the requester still gets its ack, with a zero block.
                    rs_data_next[grant_id_reg] = '0;
                    rs_ack_next[grant_id_reg]  = 1'b1;
                    timeout_err_next           = 1'b1;
                    mrq_cs_next                = 1'b0;
                    state_next                 = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rs0_ack     = rs_ack_reg[0];
    assign rs1_ack     = rs_ack_reg[1];
    assign rs0_data    = rs_data_reg[0];
    assign rs1_data    = rs_data_reg[1];
    assign mrq_cs      = mrq_cs_reg;
    assign mrq_addr    = mrq_addr_reg;
    assign mrq_rw      = mrq_rw_reg;
    assign mrq_data    = mrq_data_reg;
    assign grant_id    = grant_id_reg;
    assign busy        = busy_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter: requester and memory agents drive the DUT while a
// transaction-level reference model predicts every output on every cycle.
module tb_mem_req_arbiter;
    localparam int AW = 30;
    localparam int WW = 32;
    localparam int BS = 4;
    localparam int TO = 8;
    localparam int BW = WW * BS;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rw;
        logic [BW-1:0] data;
        int            gap;
    } req_t;

    typedef struct {
        int            lat;
        logic [BW-1:0] data;
    } mem_t;

    logic clk;
    logic rst_drv;
    logic          cs_drv   [2];
    logic          rw_drv   [2];
    logic [AW-1:0] addr_drv [2];
    logic [BW-1:0] data_drv [2];
    logic          mrs_ack_drv;
    logic [BW-1:0] mrs_data_drv;

    logic          rs0_ack, rs1_ack, mrq_cs, mrq_rw, grant_id, busy, timeout_err;
    logic [BW-1:0] rs0_data, rs1_data, mrq_data;
    logic [AW-1:0] mrq_addr;

    mem_req_arbiter #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BLOCK_SIZE(BS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst_drv),
        .rq0_addr(addr_drv[0]), .rq0_cs(cs_drv[0]), .rq0_rw(rw_drv[0]), .rq0_data(data_drv[0]),
        .rs0_ack(rs0_ack), .rs0_data(rs0_data),
        .rq1_addr(addr_drv[1]), .rq1_cs(cs_drv[1]), .rq1_rw(rw_drv[1]), .rq1_data(data_drv[1]),
        .rs1_ack(rs1_ack), .rs1_data(rs1_data),
        .mrq_addr(mrq_addr), .mrq_cs(mrq_cs), .mrq_rw(mrq_rw), .mrq_data(mrq_data),
        .mrs_ack(mrs_ack_drv), .mrs_data(mrs_data_drv),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Stimulus queues and agent state.
    req_t rq_q0[$];
    req_t rq_q1[$];
    mem_t mem_q[$];
    req_t pend   [2];
    logic have_item [2];
    int   wait_cnt  [2];
    logic mem_busy;
    int   mem_cnt;
    logic [BW-1:0] mem_dat;
    logic spur_en, rst_req, rst_auto, late_ack;

    // Reference model state (transaction level: who owns the channel and when).
    logic          m_active, m_port, m_last;
    int            m_issue_edge, m_free_edge, m_busy_clear_edge;
    logic [AW-1:0] m_addr;
    logic          m_rw;
    logic [BW-1:0] m_data;
    logic          exp_mrq_cs, exp_mrq_rw, exp_grant, exp_busy, exp_terr;
    logic [AW-1:0] exp_mrq_addr;
    logic [BW-1:0] exp_mrq_data;
    logic          exp_ack  [2];
    logic [BW-1:0] exp_data [2];
    logic          obs_ack  [2];

    task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic quiet();
        return (rq_q0.size() == 0) && (rq_q1.size() == 0) && !have_item[0] && !have_item[1]
            && !cs_drv[0] && !cs_drv[1] && !m_active && !rst_req;
    endfunction

    task automatic push_req(input int p, input logic [AW-1:0] a, input logic w,
                            input logic [BW-1:0] d, input int gap);
        req_t it;
        it.addr = a; it.rw = w; it.data = d; it.gap = gap;
        if (p == 0) rq_q0.push_back(it); else rq_q1.push_back(it);
    endtask

    task automatic push_mem(input int lat, input logic [BW-1:0] d);
        mem_t m;
        m.lat = lat; m.data = d;
        mem_q.push_back(m);
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_last = 1'b1; m_port = 1'b0;
        m_free_edge = cyc + 1; m_busy_clear_edge = -1; m_issue_edge = -10;
        exp_mrq_cs = 1'b0; exp_mrq_rw = 1'b0; exp_mrq_addr = '0; exp_mrq_data = '0;
        exp_grant = 1'b0; exp_busy = 1'b0; exp_terr = 1'b0;
        exp_data[0] = '0; exp_data[1] = '0;
    endtask

    task automatic respond(input logic [BW-1:0] d, input logic timed_out);
        exp_ack[m_port]  = 1'b1;
        exp_data[m_port] = d;
        exp_mrq_cs       = 1'b0;
        if (timed_out) exp_terr = 1'b1;
        m_active          = 1'b0;
        m_busy_clear_edge = cyc + 1;
        m_free_edge       = cyc + 2;
    endtask

    // One clock: predict the effect of this edge, compare, then drive the next edge's inputs.
    task automatic step();
        req_t it;
        mem_t m;
        int   j;
        @(posedge clk);
        cyc++;
        #1;
        exp_ack[0] = 1'b0;
        exp_ack[1] = 1'b0;
        if (rst_drv) begin
            model_reset();
        end else begin
            if (m_busy_clear_edge == cyc) exp_busy = 1'b0;
            if (m_active && cyc > m_issue_edge) begin
                j = cyc - m_issue_edge - 1;
                if (mrs_ack_drv) respond(mrs_data_drv, 1'b0);
                else if (j == TO) respond('0, 1'b1);
            end else if (m_active && cyc == m_issue_edge) begin
                exp_mrq_cs = 1'b1; exp_mrq_addr = m_addr; exp_mrq_rw = m_rw; exp_mrq_data = m_data;
            end else if (!m_active && cyc >= m_free_edge && (cs_drv[0] || cs_drv[1])) begin
                m_port = (cs_drv[0] && cs_drv[1]) ? ~m_last : cs_drv[1];
                m_last = m_port;
                m_addr = addr_drv[m_port]; m_rw = rw_drv[m_port]; m_data = data_drv[m_port];
                m_active = 1'b1; m_issue_edge = cyc + 1;
                exp_grant = m_port; exp_busy = 1'b1;
            end
        end

        check("mrq_cs", BW'(mrq_cs), BW'(exp_mrq_cs));
        check("mrq_addr", BW'(mrq_addr), BW'(exp_mrq_addr));
        check("mrq_rw", BW'(mrq_rw), BW'(exp_mrq_rw));
        check("mrq_data", mrq_data, exp_mrq_data);
        check("rs0_ack", BW'(rs0_ack), BW'(exp_ack[0]));
        check("rs1_ack", BW'(rs1_ack), BW'(exp_ack[1]));
        check("rs0_data", rs0_data, exp_data[0]);
        check("rs1_data", rs1_data, exp_data[1]);
        check("grant_id", BW'(grant_id), BW'(exp_grant));
        check("busy", BW'(busy), BW'(exp_busy));
        check("timeout_err", BW'(timeout_err), BW'(exp_terr));

        if (rst_auto) begin rst_drv = 1'b0; rst_auto = 1'b0; end
        obs_ack[0] = rs0_ack;
        obs_ack[1] = rs1_ack;

        // Requesters: hold until acked, drop for one edge, then take the next queued item.
        for (int p = 0; p < 2; p++) begin
            if (cs_drv[p]) begin
                if (obs_ack[p]) cs_drv[p] = 1'b0;
            end else if (have_item[p]) begin
                if (wait_cnt[p] == 0) begin
                    cs_drv[p] = 1'b1; have_item[p] = 1'b0;
                    addr_drv[p] = pend[p].addr; rw_drv[p] = pend[p].rw; data_drv[p] = pend[p].data;
                end else begin
                    wait_cnt[p]--;
                end
            end else if ((p == 0 && rq_q0.size() > 0) || (p == 1 && rq_q1.size() > 0)) begin
                it = (p == 0) ? rq_q0.pop_front() : rq_q1.pop_front();
                if (it.gap == 0) begin
                    cs_drv[p] = 1'b1;
                    addr_drv[p] = it.addr; rw_drv[p] = it.rw; data_drv[p] = it.data;
                end else begin
                    pend[p] = it; have_item[p] = 1'b1; wait_cnt[p] = it.gap - 1;
                end
            end
            if (!cs_drv[p]) begin
                addr_drv[p] = AW'($urandom); rw_drv[p] = 1'($urandom); data_drv[p] = rnd_block();
            end
        end

        // Memory: latency counted from the first cycle mrq_cs is seen high; -1 never answers.
        mrs_ack_drv  = 1'b0;
        mrs_data_drv = rnd_block();
        if (!mrq_cs) begin
            mem_busy = 1'b0;
        end else begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                if (mem_q.size() > 0) begin
                    m = mem_q.pop_front(); mem_cnt = m.lat; mem_dat = m.data;
                end else begin
                    mem_cnt = $urandom_range(0, 10); mem_dat = rnd_block();
                end
            end else if (mem_cnt > 0) begin
                mem_cnt--;
            end
            if (mem_cnt == 0) begin
                mrs_ack_drv = 1'b1; mrs_data_drv = mem_dat; mem_cnt = -1;
            end
        end
        if (late_ack) begin
            mrs_ack_drv = 1'b1; late_ack = 1'b0;
        end else if (!mrs_ack_drv && spur_en && (!m_active || m_issue_edge == cyc + 1)
                     && $urandom_range(0, 3) == 0) begin
            mrs_ack_drv = 1'b1;
        end
        if (rst_req && m_active && cyc >= m_issue_edge + 2) begin
            rst_drv = 1'b1; rst_auto = 1'b1; rst_req = 1'b0; late_ack = 1'b1;
        end
    endtask

    task automatic run_quiet(input int limit);
        int   n;
        logic drained;
        n = 0;
        while (!quiet() && n < limit) begin
            step();
            n++;
        end
        drained = quiet();
        check("drain", BW'(drained), BW'(1'b1));
        repeat (3) step();
    endtask

    initial begin
        rst_drv = 1'b1;
        for (int p = 0; p < 2; p++) begin
            cs_drv[p] = 1'b0; rw_drv[p] = 1'b0; addr_drv[p] = '0; data_drv[p] = '0;
            have_item[p] = 1'b0; wait_cnt[p] = 0; exp_ack[p] = 1'b0;
        end
        mrs_ack_drv = 1'b0; mrs_data_drv = '0;
        mem_busy = 1'b0; mem_cnt = -1; mem_dat = '0;
        spur_en = 1'b0; rst_req = 1'b0; rst_auto = 1'b0; late_ack = 1'b0;
        model_reset();
        repeat (3) step();
        rst_drv = 1'b0;

        // Single read on port 0, memory answers three cycles after mrq_cs.
        push_req(0, 30'h10, 1'b0, rnd_block(), 0);
        push_mem(2, {32'd4, 32'd3, 32'd2, 32'd1});
        run_quiet(100);

        // Simultaneous requests straight after reset: port 0 first.
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        push_req(0, AW'($urandom), 1'b0, rnd_block(), 0);
        push_req(1, AW'($urandom), 1'b0, rnd_block(), 0);
        push_mem(0, rnd_block());
        push_mem(0, rnd_block());
        run_quiet(100);

        // Fairness: both ports keep requesting back to back.
        for (int i = 0; i < 3; i++) begin
            push_req(0, AW'($urandom), 1'($urandom), rnd_block(), 0);
            push_req(1, AW'($urandom), 1'($urandom), rnd_block(), 0);
            push_mem(0, rnd_block());
            push_mem(0, rnd_block());
        end
        run_quiet(200);

        // Write forwarding at the top address.
        push_req(1, 30'h3FFFFFFF, 1'b1, {32'hD, 32'hC, 32'hB, 32'hA}, 0);
        push_mem(4, rnd_block());
        run_quiet(100);

        // Timeout with a silent memory, then a normal request.
        push_req(0, AW'($urandom), 1'b0, rnd_block(), 0);
        push_mem(-1, '0);
        push_req(0, AW'($urandom), 1'b1, rnd_block(), 3);
        push_mem(1, rnd_block());
        run_quiet(200);

        // Reset while waiting on memory; the held request is served again afterwards.
        push_req(1, AW'($urandom), 1'b0, rnd_block(), 0);
        push_mem(-1, '0);
        rst_req = 1'b1;
        run_quiet(200);

        // Random traffic with random latencies (some time out) and spurious acks.
        spur_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_req($urandom_range(0, 1), AW'($urandom), 1'($urandom), rnd_block(),
                     $urandom_range(0, 4));
        end
        run_quiet(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
